partition_resp_checker: RTL and testbench
=========================================

Name: partition_resp_checker

Overview:
- Hardware counterpart of the exhaustive partition testbench.
- Drives every input pattern of a partitioned sub-circuit, one per cycle.
- Reads back the exact and approximate partition outputs for each pattern and accumulates error metrics for the partition evaluator (error count, Hamming-distance sum, max absolute error).
- Sits between the pattern source and the exact/approx partition instances inside the evaluation harness.

Parameters:
- IN_W, 7, partition primary-input width; the sweep covers 2^IN_W patterns.
- OUT_W, 4, partition primary-output width.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  single-cycle request to begin a sweep.
- abort  input  1  terminate the sweep and return to IDLE.
- pi  output  IN_W  registered pattern driven to both partitions.
- exact_po  input  OUT_W  golden partition output (combinational from pi).
- approx_po  input  OUT_W  approximate partition output (combinational from pi).
- busy  output  1  high in SWEEP.
- done  output  1  high in DONE; metrics valid.
- err_count  output  IN_W+1  number of patterns with exact_po != approx_po.
- hd_sum  output  IN_W+$clog2(OUT_W+1)  sum of per-pattern Hamming distances.
- max_abs_err  output  OUT_W  max |exact_po - approx_po|, unsigned compare.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, pi=0, busy=0, done=0, all metric registers 0.
- FSM states: IDLE, SWEEP, DONE.
- IDLE, start=1: clear all metrics, pi=0, go to SWEEP.
- SWEEP, each clock edge:
  - Sample exact_po/approx_po for the current pi.
  - Update the metrics.
  - Increment pi.
- SWEEP exit: the edge that samples pi = 2^IN_W-1 goes to DONE. pi wraps to 0 on that same edge.
- Sweep length: exactly 2^IN_W cycles in SWEEP. Default 128.
- Latency: done rises on the edge that samples the final pattern. Metrics are final that same cycle.
- DONE: hold metrics and done until start (re-sweep, metrics cleared) or abort (to IDLE, metrics held).
- start in SWEEP: ignored.
- abort in SWEEP or DONE: next state IDLE, pi=0. Metrics hold their partial/final values. done=0.
- abort and start in the same cycle: abort wins.
- Per-pattern arithmetic:
  - diff = exact_po ^ approx_po.
  - hd = popcount(diff), width $clog2(OUT_W+1).
  - err_count increments by 1 iff diff != 0.
  - abs_err = exact_po >= approx_po ? exact_po - approx_po : approx_po - exact_po.
  - max_abs_err updates when abs_err > max_abs_err.
- Widths are sized so err_count and hd_sum cannot overflow over one full sweep. No saturation logic.
- Reset mid-sweep: immediate IDLE, metrics cleared.

Optional Feature:
- Macro: PART_RESP_MISR_EN.
- Defined:
  - Adds output port signature [15:0]: a 16-bit MISR, polynomial x^16+x^12+x^3+x+1, seed 16'hFFFF.
  - Seed is loaded with the metric clear.
  - Each SWEEP edge XORs approx_po, zero-extended, into the shifted state.
  - Held in DONE/IDLE; reset value 16'hFFFF.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package part_eval_pkg:
  - State enum (IDLE/SWEEP/DONE).
  - Metric-width localparam functions.
  - MISR polynomial and seed constants.
- One sub-module, part_err_metric: purely combinational diff/popcount/abs-error for one pattern. Instantiated once.
- FSM, counters and accumulators stay in the top.

Test Plan:
- approx_po tied to exact_po (exact_po=pi[3:0]), start pulse:
  - done after 128 SWEEP cycles.
  - err_count=0, hd_sum=0, max_abs_err=0.
- approx_po = exact_po ^ 4'b0001 for every pattern: err_count=128, hd_sum=128, max_abs_err=1.
- exact_po=pi[3:0], approx_po=0: err_count=120, hd_sum=256, max_abs_err=15.
- start pulsed again at sweep cycle 40: ignored; done still after 128 cycles; same metrics.
- abort at sweep cycle 50: IDLE next cycle, pi=0, busy=0, done=0; err_count holds the partial value.
- rst_n low at sweep cycle 60, asynchronous mid-cycle: outputs zero immediately. A fresh start then gives a full 128-cycle sweep.
- With PART_RESP_MISR_EN:
  - Two sweeps with identical stimulus yield identical signature.
  - Flipping approx_po bit0 at a single pattern changes the signature.

Source files
------------

// File: rtl/part_eval_pkg.sv
// part_eval_pkg
//   Shared types and constants for the partition evaluation harness.
//   - part_state_e : sweep controller states (IDLE / SWEEP / DONE)
//   - hd_w / err_cnt_w / hd_sum_w : metric register widths derived from the
//     partition input/output widths. They are sized so that one full sweep
//     can never overflow the accumulators.
//   - MISR_W / MISR_POLY / MISR_SEED : response-signature register constants
//     used when PART_RESP_MISR_EN is defined.
package part_eval_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } part_state_e;

  // Width of a per-pattern Hamming distance (0..out_w inclusive).
  function automatic int hd_w(input int out_w);
    return $clog2(out_w + 1);
  endfunction

  // Mismatch counter width: it must hold the value 2^in_w.
  function automatic int err_cnt_w(input int in_w);
    return in_w + 1;
  endfunction

  // Hamming-distance accumulator width: 2^in_w patterns of up to out_w each.
  function automatic int hd_sum_w(input int in_w, input int out_w);
    return in_w + $clog2(out_w + 1);
  endfunction

  // x^16 + x^12 + x^3 + x + 1 (the x^16 term is implicit).
  localparam int          MISR_W    = 16;
  localparam logic [15:0] MISR_POLY = 16'h100B;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

endpackage

// File: rtl/part_err_metric.sv
// part_err_metric
//   Purely combinational per-pattern error metrics between the golden and
//   approximate partition outputs.
//   Ports:
//     exact_po  in  [OUT_W-1:0] golden output
//     approx_po in  [OUT_W-1:0] approximate output
//     mismatch  out             1 when the two outputs differ
//     hd        out [HD_W-1:0]  popcount of exact_po ^ approx_po
//     abs_err   out [OUT_W-1:0] |exact_po - approx_po|, unsigned
module part_err_metric
  import part_eval_pkg::*;
#(
  parameter int OUT_W = 4,
  parameter int HD_W  = hd_w(OUT_W)
) (
  input  logic [OUT_W-1:0] exact_po,
  input  logic [OUT_W-1:0] approx_po,
  output logic             mismatch,
  output logic [HD_W-1:0]  hd,
  output logic [OUT_W-1:0] abs_err
);

  logic [OUT_W-1:0] diff;

  assign diff     = exact_po ^ approx_po;
  assign mismatch = |diff;

  always_comb begin
    hd = '0;
    for (int i = 0; i < OUT_W; i++) begin
      hd = hd + HD_W'(diff[i]);
    end
  end

  // Subtract in the direction that cannot underflow.
  always_comb begin
    if (exact_po >= approx_po) begin
      abs_err = exact_po - approx_po;
    end else begin
      abs_err = approx_po - exact_po;
    end
  end

endmodule

// File: rtl/partition_resp_checker.sv
// partition_resp_checker
//   Exhaustive response checker for a partitioned sub-circuit. On start it
//   drives every one of the 2^IN_W input patterns on pi (one per cycle),
//   samples the combinational exact/approx partition outputs and accumulates
//   error metrics: mismatch count, Hamming-distance sum and maximum absolute
//   error.
//
//   Control handshake: start and abort are single-cycle level requests
//   sampled on every rising clk edge; there is no ready/acknowledge. start is
//   accepted only in IDLE or DONE and is ignored in SWEEP. abort is honoured
//   in SWEEP or DONE and always takes priority over start in the same cycle.
//   done is a level that stays high (metrics valid) until the next accepted
//   start or abort.
//
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     start        begin a sweep (clears metrics)
//     abort        stop and return to IDLE (metrics held)
//     pi           [IN_W-1:0] registered pattern to both partitions
//     exact_po     [OUT_W-1:0] golden partition output
//     approx_po    [OUT_W-1:0] approximate partition output
//     busy         high in SWEEP
//     done         high in DONE
//     err_count    patterns with exact_po != approx_po
//     hd_sum       sum of per-pattern Hamming distances
//     max_abs_err  maximum unsigned absolute error
//     signature    [15:0] MISR over approx_po (only with PART_RESP_MISR_EN)
//
//   Build option: define PART_RESP_MISR_EN to add the signature output.
module partition_resp_checker
  import part_eval_pkg::*;
#(
  parameter int IN_W  = 7,
  parameter int OUT_W = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  output logic [IN_W-1:0]               pi,
  input  logic [OUT_W-1:0]              exact_po,
  input  logic [OUT_W-1:0]              approx_po,
  output logic                          busy,
  output logic                          done,
  output logic [err_cnt_w(IN_W)-1:0]    err_count,
  output logic [hd_sum_w(IN_W,OUT_W)-1:0] hd_sum,
  output logic [OUT_W-1:0]              max_abs_err
`ifdef PART_RESP_MISR_EN
  ,
  output logic [MISR_W-1:0]             signature
`endif
);

  localparam int HD_W   = hd_w(OUT_W);
  localparam int ERR_W  = err_cnt_w(IN_W);
  localparam int HSUM_W = hd_sum_w(IN_W, OUT_W);
  localparam logic [IN_W-1:0] PI_LAST = {IN_W{1'b1}};

  part_state_e state, state_nxt;

  // Decoded per-cycle actions from the FSM.
  logic clr_metrics;  // load metric registers with their clear values
  logic acc_en;       // fold the current pattern into the metrics
  logic pi_zero;      // restart the pattern counter

  logic             pat_mismatch;
  logic [HD_W-1:0]  pat_hd;
  logic [OUT_W-1:0] pat_abs_err;

  part_err_metric #(
    .OUT_W (OUT_W),
    .HD_W  (HD_W)
  ) u_metric (
    .exact_po  (exact_po),
    .approx_po (approx_po),
    .mismatch  (pat_mismatch),
    .hd        (pat_hd),
    .abs_err   (pat_abs_err)
  );

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_metrics = 1'b0;
    acc_en      = 1'b0;
    pi_zero     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt   = SWEEP;
          clr_metrics = 1'b1;
          pi_zero     = 1'b1;
        end
      end
      SWEEP: begin
        if (abort) begin
          state_nxt = IDLE;
          pi_zero   = 1'b1;
        end else begin
          acc_en = 1'b1;
          // The edge that samples the last pattern finishes the sweep; pi
          // wraps back to zero on that same edge through the increment.
          if (pi == PI_LAST) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (abort) begin
          state_nxt = IDLE;
          pi_zero   = 1'b1;
        end else if (start) begin
          state_nxt   = SWEEP;
          clr_metrics = 1'b1;
          pi_zero     = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        pi_zero   = 1'b1;
      end
    endcase
  end

  assign busy = (state == SWEEP);
  assign done = (state == DONE);

  // ---------------------------------------------------------------------
  // Pattern counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pi <= '0;
    end else if (pi_zero) begin
      pi <= '0;
    end else if (acc_en) begin
      pi <= pi + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Metric accumulators
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count   <= '0;
      hd_sum      <= '0;
      max_abs_err <= '0;
    end else if (clr_metrics) begin
      err_count   <= '0;
      hd_sum      <= '0;
      max_abs_err <= '0;
    end else if (acc_en) begin
      err_count <= err_count + ERR_W'(pat_mismatch);
      hd_sum    <= hd_sum + HSUM_W'(pat_hd);
      if (pat_abs_err > max_abs_err) begin
        max_abs_err <= pat_abs_err;
      end
    end
  end

`ifdef PART_RESP_MISR_EN
  // ---------------------------------------------------------------------
  // Response signature: Galois-style shift with feedback from the MSB, then
  // the approximate output is folded into the low bits.
  // ---------------------------------------------------------------------
  logic [MISR_W-1:0] sig_nxt;

  always_comb begin
    sig_nxt = {signature[MISR_W-2:0], 1'b0};
    if (signature[MISR_W-1]) begin
      sig_nxt = sig_nxt ^ MISR_POLY;
    end
    sig_nxt = sig_nxt ^ MISR_W'(approx_po);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signature <= MISR_SEED;
    end else if (clr_metrics) begin
      signature <= MISR_SEED;
    end else if (acc_en) begin
      signature <= sig_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_partition_resp_checker.sv
// tb_partition_resp_checker
//   Directed bench for partition_resp_checker (IN_W=7, OUT_W=4). The partition
//   outputs are modelled in the bench as functions of pi. A transaction-level
//   model tracks phase / pattern count; expected metrics are recomputed from
//   scratch over the patterns consumed so far and compared every cycle.
//   Define PART_RESP_MISR_EN to also cover the signature output.
module tb_partition_resp_checker;

  localparam int IN_W  = 7;
  localparam int OUT_W = 4;
  localparam int NPAT  = 128;

  // Clock / reset / DUT signals
  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [6:0]  pi;
  logic [3:0]  exact_po;
  logic [3:0]  approx_po;
  logic        busy;
  logic        done;
  logic [7:0]  err_count;
  logic [9:0]  hd_sum;
  logic [3:0]  max_abs_err;
`ifdef PART_RESP_MISR_EN
  logic [15:0] signature;
`endif

  always #5 clk = ~clk;

  partition_resp_checker #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .pi          (pi),
    .exact_po    (exact_po),
    .approx_po   (approx_po),
    .busy        (busy),
    .done        (done),
    .err_count   (err_count),
    .hd_sum      (hd_sum),
    .max_abs_err (max_abs_err)
`ifdef PART_RESP_MISR_EN
    ,
    .signature   (signature)
`endif
  );

  // Partition stand-ins
  int mode     = 0;   // 0: approx=exact, 1: exact^1, 2: zero, 3: pi[6:3]
  int flip_pat = -1;  // pattern index whose approx bit0 is flipped

  function automatic logic [3:0] approx_of(input int md, input int fp, input int p);
    logic [6:0] pv;
    logic [3:0] a;
    pv = p[6:0];
    case (md)
      0:       a = pv[3:0];
      1:       a = pv[3:0] ^ 4'b0001;
      2:       a = 4'b0000;
      default: a = pv[6:3];
    endcase
    if (p == fp) a = a ^ 4'b0001;
    return a;
  endfunction

  always_comb begin
    exact_po  = pi[3:0];
    approx_po = approx_of(mode, flip_pat, int'(pi));
  end

  // Scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference metrics over the first n patterns of a sweep
  function automatic void ref_metrics(input int md, input int fp, input int n,
                                      output int e, output int h, output int mx,
                                      output logic [15:0] sg);
    int ex, ap, ad;
    logic [3:0] d;
    e = 0; h = 0; mx = 0; sg = 16'hFFFF;
    for (int p = 0; p < n; p++) begin
      ex = p % 16;
      ap = int'(approx_of(md, fp, p));
      d  = 4'(ex ^ ap);
      if (d != 0) e++;
      h += $countones(d);
      ad = (ex > ap) ? ex - ap : ap - ex;
      if (ad > mx) mx = ad;
      sg = {sg[14:0], 1'b0} ^ (sg[15] ? 16'h100B : 16'h0000) ^ {12'h000, 4'(ap)};
    end
  endfunction

  // Transaction-level model: phase 0=idle 1=sweep 2=done
  int m_phase, m_pi, m_cnt, m_mode, m_flip;
  bit chk_en = 1'b0;

  task automatic model_reset();
    m_phase = 0; m_pi = 0; m_cnt = 0; m_mode = 0; m_flip = -1;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else if (abort) begin
      if (m_phase != 0) begin
        m_phase = 0;
        m_pi    = 0;
      end
    end else if (start && m_phase != 1) begin
      m_phase = 1; m_pi = 0; m_cnt = 0; m_mode = mode; m_flip = flip_pat;
    end else if (m_phase == 1) begin
      m_cnt++;
      m_pi = (m_pi + 1) % NPAT;
      if (m_cnt == NPAT) m_phase = 2;
    end
  endtask

  // Compare process: every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      int e, h, mx;
      logic [15:0] sg;
      ref_metrics(m_mode, m_flip, m_cnt, e, h, mx, sg);
      chk("pi", 32'(pi), 32'(m_pi));
      chk("busy", 32'(busy), 32'(m_phase == 1));
      chk("done", 32'(done), 32'(m_phase == 2));
      chk("err_count", 32'(err_count), 32'(e));
      chk("hd_sum", 32'(hd_sum), 32'(h));
      chk("max_abs_err", 32'(max_abs_err), 32'(mx));
`ifdef PART_RESP_MISR_EN
      chk("signature", 32'(signature), 32'(sg));
`endif
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1 model_step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 300) begin
      tick();
      cyc++;
    end
  endtask

  int cyc;
  logic [15:0] sig1;

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_pi", 32'(pi), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_err", 32'(err_count), 0);

    // Identical outputs
    mode = 0;
    pulse_start();
    wait_done(cyc);
    chk("t1_len", 32'(cyc), 128);
    chk("t1_err", 32'(err_count), 0);
    chk("t1_hd", 32'(hd_sum), 0);
    chk("t1_max", 32'(max_abs_err), 0);
    repeat (3) tick();

    // Bit0 always flipped
    mode = 1;
    pulse_start();
    wait_done(cyc);
    chk("t2_len", 32'(cyc), 128);
    chk("t2_err", 32'(err_count), 128);
    chk("t2_hd", 32'(hd_sum), 128);
    chk("t2_max", 32'(max_abs_err), 1);

    // Approx stuck at zero
    mode = 2;
    pulse_start();
    wait_done(cyc);
    chk("t3_err", 32'(err_count), 120);
    chk("t3_hd", 32'(hd_sum), 256);
    chk("t3_max", 32'(max_abs_err), 15);

    // start re-pulsed mid-sweep is ignored
    pulse_start();
    repeat (39) tick();
    pulse_start();
    wait_done(cyc);
    chk("t4_len", 32'(40 + cyc), 128);
    chk("t4_err", 32'(err_count), 120);
    chk("t4_hd", 32'(hd_sum), 256);

    // Abort after 50 patterns: patterns 0,16,32,48 match, 46 mismatch
    pulse_start();
    repeat (50) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_pi", 32'(pi), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_done", 32'(done), 0);
    chk("t5_err", 32'(err_count), 46);
    repeat (4) tick();
    chk("t5_err_hold", 32'(err_count), 46);

    // Asynchronous reset mid-sweep
    mode = 1;
    pulse_start();
    repeat (60) tick();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_pi", 32'(pi), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_err", 32'(err_count), 0);
    chk("t6_hd", 32'(hd_sum), 0);
    tick();
    rst_n = 1'b1;
    pulse_start();
    wait_done(cyc);
    chk("t6_len", 32'(cyc), 128);
    chk("t6_err_full", 32'(err_count), 128);

`ifdef PART_RESP_MISR_EN
    mode = 3;
    flip_pat = -1;
    pulse_start();
    wait_done(cyc);
    sig1 = signature;
    pulse_start();
    wait_done(cyc);
    chk("misr_repeat", 32'(signature), 32'(sig1));
    flip_pat = 37;
    pulse_start();
    wait_done(cyc);
    chk("misr_flip_differs", 32'(signature != sig1), 1);
    flip_pat = -1;
`endif

    repeat (2) tick();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
